led_bit_serializer: RTL and testbench
=====================================

Name: led_bit_serializer

Overview:
- Parametrised successor to the single-LED 8-bit rotating-mask shifter.
- Accepts a WIDTH-bit word over a valid/ready handshake and serialises it onto one registered output pin.
- Each bit is held for BIT_CYCLES clocks; frames are separated by GAP_BITS idle bit-times.
- Bit order is selectable. The last word can optionally replay continuously. Sits between control logic and an LED/debug pin.

Parameters:
- WIDTH, 8, data word width in bits (>=2).
- BIT_CYCLES, 1, sys_clk cycles each bit is held (>=1).
- GAP_BITS, 0, idle-low bit-times inserted after each frame (>=0).
- MSB_FIRST, 0, 0 = bit 0 sent first; 1 = bit WIDTH-1 sent first.
- REPEAT, 1, 1 = replay the held word when no new word is offered at frame end; 0 = return to IDLE.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous reset, active-high.
- data_in  in  WIDTH  word to serialise.
- data_valid  in  1  data_in is valid.
- data_ready  out  1  block accepts data_in this cycle.
- ser_out  out  1  serial output, registered.
- bit_strobe  out  1  one-cycle pulse on the first cycle of each data bit.
- frame_done  out  1  one-cycle pulse on the last cycle of a frame (including gap).
- busy  out  1  state is not IDLE.

Behaviour:
- Clock and reset: single clock sys_clk; sys_rst is synchronous, active-high. All state is updated on the rising edge.
- Reset values: ser_out=0, busy=0, bit_strobe=0, frame_done=0, held word=0, state=IDLE. data_ready=1 in the cycle after reset.
- Reset mid-frame: aborts the frame immediately. ser_out=0 the next cycle, with no frame_done pulse.
- State IDLE:
  - ser_out=0, data_ready=1.
  - On accept (valid&&ready), latch data_in, clear bit index and cycle counter, and go to SHIFT.
- State SHIFT:
  - ser_out = held word bit at index i, or WIDTH-1-i when MSB_FIRST=1.
  - The first bit appears on ser_out the cycle after accept (latency 1).
  - bit_strobe is high on the first cycle of each bit, coincident with ser_out changing.
  - The cycle counter counts 0..BIT_CYCLES-1. At wrap, i increments.
  - After bit WIDTH-1 wraps: go to GAP if GAP_BITS>0 (or PARITY, see optional feature), otherwise end the frame.
- State GAP: ser_out=0 for GAP_BITS*BIT_CYCLES cycles, then end the frame.
- Frame end (the last cycle of the final data/parity/gap bit):
  - frame_done=1 and data_ready=1 in this cycle.
  - If data_valid: the new word is latched, and its first bit appears the next cycle (back-to-back, no idle cycle).
  - Else if REPEAT=1: the held word is restarted, with no idle cycle.
  - Else: go to IDLE.
- data_ready is 0 at every other cycle in SHIFT/GAP/PARITY. data_in is ignored while data_ready=0.
- Counters:
  - The bit index is $clog2(WIDTH) wide.
  - The cycle counter is $clog2(BIT_CYCLES)+1 wide.
  - The gap counter is sized for GAP_BITS*BIT_CYCLES.
  - No counter may overflow for legal parameters.
- BIT_CYCLES=1: bit_strobe is high every SHIFT cycle; the frame lasts exactly WIDTH cycles.
- busy=0 only in IDLE.

Optional Feature:
- Macro: LED_SERIALIZER_PARITY_EN.
- When defined:
  - A PARITY state follows the last data bit.
  - It outputs the even-parity bit (XOR of the held word) for BIT_CYCLES cycles, with bit_strobe asserted on its first cycle.
  - GAP, if any, follows it. Frame length grows by one bit-time.
- When undefined: no PARITY state and no parity logic is synthesised.

Decomposition:
- Shared package led_pkg:
  - state enum type (IDLE, SHIFT, PARITY, GAP);
  - function clog2_min1 for counter sizing.
- Sub-module bit_timer:
  - cycle counter with a BIT_CYCLES parameter;
  - inputs: clear, enable; outputs: first_cycle, last_cycle.
  - Instantiated once for bit timing and reused for gap timing.

Test Plan:
- Reset and idle: hold sys_rst 3 cycles, then release with no valid -> ser_out=0, busy=0, data_ready=1.
- LSB-first framing: WIDTH=8, BIT_CYCLES=1, REPEAT=0; send 0xA5 -> ser_out over the next 8 cycles = 1,0,1,0,0,1,0,1. frame_done on the 8th cycle, then IDLE.
- MSB-first with bit stretching: MSB_FIRST=1, BIT_CYCLES=4, GAP_BITS=2; send 0x81 -> 4 cycles of 1, 24 cycles of 0, 4 cycles of 1, then 8 cycles of 0 gap. bit_strobe pulses 8 times, 4 cycles apart.
- Back-to-back and repeat: send 0x0F, then hold 0xF0 valid -> accepted exactly on the frame_done cycle with no idle gap. REPEAT=1 with valid low -> 0x0F replays continuously.
- Reset mid-frame: assert sys_rst at bit 3 of 0xFF -> ser_out=0 next cycle, no frame_done. The next word starts from bit 0.
- Parity (macro defined): send 0x07 -> 9th bit-time ser_out=1. Send 0x03 -> 9th bit-time ser_out=0.

Source files
------------

// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_pkg
//  Description : Shared types and sizing helpers for the LED bit serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

  // Serializer sequencing states; PARITY is only entered in parity builds
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  // Counter width for n distinct values, never narrower than one bit
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_bit_serializer_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bit_timer
//  Description : Bit-time cycle counter. Counts 0..BIT_CYCLES-1 and wraps,
//                flagging the first and last cycle of every bit-time.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_timer #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_first_cycle,
  output logic o_last_cycle
);

  localparam int              c_CW   = $clog2(BIT_CYCLES) + 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(BIT_CYCLES - 1);

  logic [c_CW-1:0] r_cnt;

  // Free-running bit-time counter, wrapping at the last cycle of each bit
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= o_last_cycle ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_first_cycle = (r_cnt == '0);
  assign o_last_cycle  = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/led_bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : led_bit_serializer
//  Description : Serialises a WIDTH-bit word onto a single registered pin,
//                each bit held BIT_CYCLES clocks, frames followed by GAP_BITS
//                idle bit-times. Optional continuous replay of the last word.
//                Build option: define LED_SERIALIZER_PARITY_EN to append an
//                even-parity bit-time after the data bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_bit_serializer
  import led_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1,
  parameter int GAP_BITS   = 0,
  parameter int MSB_FIRST  = 0,
  parameter int REPEAT     = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             bit_strobe,
  output logic             frame_done,
  output logic             busy
);

  localparam int              c_IW       = clog2_min1(WIDTH);
  localparam int              c_GW       = clog2_min1(GAP_BITS);
  localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(WIDTH - 1);
  localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam bit              c_HAS_GAP  = (GAP_BITS > 0);

  state_t           r_state;
  logic [c_IW-1:0]  r_idx;
  logic [c_GW-1:0]  r_gap;    // counts gap bit-times; the timer counts cycles within each
  logic [WIDTH-1:0] r_word;
  logic             r_ser_out;

  logic w_first;
  logic w_last;
  logic w_frame_end;
  logic w_ready;
  logic w_accept;

  // Single timer serves data, parity and gap bit-times; held at zero in IDLE
  bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_timer (
    .clk           (sys_clk),
    .rst           (sys_rst),
    .i_clear       (r_state == ST_IDLE),
    .i_enable      (r_state != ST_IDLE),
    .o_first_cycle (w_first),
    .o_last_cycle  (w_last)
  );

  // Selects the bit sent at a given position, honouring the bit order
  function automatic logic pick(input logic [WIDTH-1:0] word, input logic [c_IW-1:0] idx);
    return (MSB_FIRST != 0) ? word[c_IDX_LAST - idx] : word[idx];
  endfunction

  // Frame-end decode and handshake; ready only in IDLE or on the final frame cycle
  always_comb begin
    w_frame_end = 1'b0;
    case (r_state)
`ifdef LED_SERIALIZER_PARITY_EN
      ST_PARITY: w_frame_end = w_last && !c_HAS_GAP;
`else
      ST_SHIFT:  w_frame_end = w_last && (r_idx == c_IDX_LAST) && !c_HAS_GAP;
`endif
      ST_GAP:    w_frame_end = w_last && (r_gap == c_GAP_LAST);
      default:   w_frame_end = 1'b0;
    endcase
    w_ready  = (r_state == ST_IDLE) || w_frame_end;
    w_accept = data_valid && w_ready;
  end

  // Sequencer; ser_out is registered alongside the state that owns it
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_gap     <= '0;
      r_word    <= '0;
      r_ser_out <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state   <= ST_SHIFT;
            r_idx     <= '0;
            r_word    <= data_in;
            r_ser_out <= pick(data_in, '0);
          end
        end
        ST_SHIFT: begin
          if (w_last) begin
            if (r_idx != c_IDX_LAST) begin
              r_idx     <= r_idx + 1'b1;
              r_ser_out <= pick(r_word, r_idx + 1'b1);
            end
`ifdef LED_SERIALIZER_PARITY_EN
            else begin
              r_state   <= ST_PARITY;
              r_ser_out <= ^r_word;
            end
`else
            else if (c_HAS_GAP) begin
              r_state   <= ST_GAP;
              r_gap     <= '0;
              r_ser_out <= 1'b0;
            end
`endif
          end
        end
`ifdef LED_SERIALIZER_PARITY_EN
        ST_PARITY: begin
          if (w_last && c_HAS_GAP) begin
            r_state   <= ST_GAP;
            r_gap     <= '0;
            r_ser_out <= 1'b0;
          end
        end
`endif
        ST_GAP: begin
          if (w_last && (r_gap != c_GAP_LAST)) begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_ser_out <= 1'b0;
        end
      endcase

      // Frame end overrides: take a new word, replay, or fall back to IDLE
      if (w_frame_end) begin
        if (w_accept) begin
          r_state   <= ST_SHIFT;
          r_idx     <= '0;
          r_word    <= data_in;
          r_ser_out <= pick(data_in, '0);
        end else if (REPEAT != 0) begin
          r_state   <= ST_SHIFT;
          r_idx     <= '0;
          r_ser_out <= pick(r_word, '0);
        end else begin
          r_state   <= ST_IDLE;
          r_ser_out <= 1'b0;
        end
      end
    end
  end

  assign ser_out    = r_ser_out;
  assign data_ready = w_ready;
  assign busy       = (r_state != ST_IDLE);
`ifdef LED_SERIALIZER_PARITY_EN
  assign bit_strobe = w_first && ((r_state == ST_SHIFT) || (r_state == ST_PARITY));
`else
  assign bit_strobe = w_first && (r_state == ST_SHIFT);
`endif
  assign frame_done = w_frame_end;

endmodule
`default_nettype wire

// File: tb/tb_led_bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_bit_serializer
//  Description : Self-checking bench for led_bit_serializer. Two instances:
//                A = LSB-first, 1 cycle/bit, no gap, no replay;
//                B = MSB-first, 4 cycles/bit, 2 gap bits, replay.
//                Honours LED_SERIALIZER_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_bit_serializer;

`ifdef LED_SERIALIZER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int W = 8;

  typedef struct packed {
    logic ser;
    logic stb;
    logic done;
    logic rdy;
    logic busy;
  } outs_t;

  typedef struct {
    logic [7:0] word;
    logic [7:0] seq;   // expected serial bits in time order, leftmost first
    logic       par;
  } vec_t;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic       vld [2];
  logic [7:0] dat [2];
  logic       ser [2];
  logic       stb [2];
  logic       done[2];
  logic       rdy [2];
  logic       bsy [2];

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  led_bit_serializer #(.WIDTH(8), .BIT_CYCLES(1), .GAP_BITS(0), .MSB_FIRST(0), .REPEAT(0)) u_dut_a (
    .sys_clk(clk), .sys_rst(sys_rst), .data_in(dat[0]), .data_valid(vld[0]), .data_ready(rdy[0]),
    .ser_out(ser[0]), .bit_strobe(stb[0]), .frame_done(done[0]), .busy(bsy[0]));

  led_bit_serializer #(.WIDTH(8), .BIT_CYCLES(4), .GAP_BITS(2), .MSB_FIRST(1), .REPEAT(1)) u_dut_b (
    .sys_clk(clk), .sys_rst(sys_rst), .data_in(dat[1]), .data_valid(vld[1]), .data_ready(rdy[1]),
    .ser_out(ser[1]), .bit_strobe(stb[1]), .frame_done(done[1]), .busy(bsy[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model: frame position arithmetic ----------------
  function automatic int bc_of(input int d);   return (d == 0) ? 1 : 4; endfunction
  function automatic int gap_of(input int d);  return (d == 0) ? 0 : 2; endfunction
  function automatic bit msb_of(input int d);  return d == 1; endfunction
  function automatic bit rep_of(input int d);  return d == 1; endfunction
  function automatic int flen(input int d);    return (W + PB + gap_of(d)) * bc_of(d); endfunction

  bit         m_active[2];
  int         m_pos   [2];
  logic [7:0] m_word  [2];

  function automatic outs_t model_out(input int d);
    outs_t o;
    int    t;
    logic [7:0] w;
    o = '0;
    if (!m_active[d]) begin
      o.rdy = 1'b1;
      return o;
    end
    w      = m_word[d];
    o.busy = 1'b1;
    t      = m_pos[d] / bc_of(d);
    if (t < W) begin
      o.ser = w[msb_of(d) ? (W - 1 - t) : t];
      o.stb = (m_pos[d] % bc_of(d)) == 0;
    end else if (PB == 1 && t == W) begin
      o.ser = ^w;
      o.stb = (m_pos[d] % bc_of(d)) == 0;
    end
    o.done = (m_pos[d] == flen(d) - 1);
    o.rdy  = o.done;
    return o;
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_active[d] = 1'b0;
      m_pos[d]    = 0;
      m_word[d]   = '0;
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      outs_t o;
      o = model_out(d);
      if (sys_rst) begin
        m_active[d] = 1'b0;
        m_pos[d]    = 0;
      end else if (!m_active[d]) begin
        if (vld[d]) begin
          m_active[d] = 1'b1;
          m_pos[d]    = 0;
          m_word[d]   = dat[d];
        end
      end else if (o.done) begin
        if (vld[d]) begin
          m_word[d] = dat[d];
          m_pos[d]  = 0;
        end else if (rep_of(d)) begin
          m_pos[d] = 0;
        end else begin
          m_active[d] = 1'b0;
        end
      end else begin
        m_pos[d]++;
      end
    end
  end

  // Scoreboard: every cycle, both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("sb_a", {ser[0], stb[0], done[0], rdy[0], bsy[0]}, model_out(0));
      chk("sb_b", {ser[1], stb[1], done[1], rdy[1], bsy[1]}, model_out(1));
    end
  end

  task automatic pulse_reset();
    @(posedge clk); #2 sys_rst = 1'b1;
    @(posedge clk); #2 sys_rst = 1'b0;
  endtask

  task automatic send(input int d, input logic [7:0] w);
    @(posedge clk); #2 vld[d] = 1'b1; dat[d] = w;
    @(posedge clk); #2 vld[d] = 1'b0;
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while (bsy[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_a_timeout", bsy[0], 1'b0);
  endtask

  vec_t tbl[6];

  initial begin
    logic [7:0] sq;
    int nstb, ndone, lb;
    tbl[0] = '{8'hA5, 8'b10100101, 1'b0};
    tbl[1] = '{8'h01, 8'b10000000, 1'b1};
    tbl[2] = '{8'h3C, 8'b00111100, 1'b0};
    tbl[3] = '{8'hC8, 8'b00010011, 1'b1};
    tbl[4] = '{8'h07, 8'b11100000, 1'b1};
    tbl[5] = '{8'h03, 8'b11000000, 1'b0};

    sys_rst = 1'b1;
    vld[0] = 1'b0; vld[1] = 1'b0; dat[0] = '0; dat[1] = '0;
    @(posedge clk); #1 chk_en = 1'b1;
    @(posedge clk); @(posedge clk); #2 sys_rst = 1'b0;

    // Reset / idle
    @(negedge clk);
    chk("rst_ser_a", ser[0], 1'b0); chk("rst_busy_a", bsy[0], 1'b0); chk("rst_rdy_a", rdy[0], 1'b1);
    chk("rst_ser_b", ser[1], 1'b0); chk("rst_busy_b", bsy[1], 1'b0); chk("rst_rdy_b", rdy[1], 1'b1);

    // Table: LSB-first frames on A
    for (int i = 0; i < 6; i++) begin
      send(0, tbl[i].word);
      sq = tbl[i].seq;
      for (int k = 0; k < W; k++) begin
        @(negedge clk);
        chk("tbl_ser", ser[0], sq[W-1-k]);
        chk("tbl_stb", stb[0], 1'b1);
        if (k == W - 1) chk("tbl_done", done[0], (PB == 0));
      end
      if (PB == 1) begin
        @(negedge clk);
        chk("tbl_par", ser[0], tbl[i].par);
        chk("tbl_done_par", done[0], 1'b1);
      end
      @(negedge clk);
      chk("tbl_idle", bsy[0], 1'b0);
    end

    // MSB-first, 4 cycles/bit, 2-bit gap on B: 0x81
    send(1, 8'h81);
    lb = flen(1); nstb = 0; ndone = 0;
    for (int c = 0; c < lb; c++) begin
      @(negedge clk);
      if (ser[1] !== ((c < 4) || (c >= 28 && c < 32))) chk("b81_ser", ser[1], ((c < 4) || (c >= 28 && c < 32)));
      nstb  += int'(stb[1]);
      ndone += int'(done[1]);
      if (c == lb - 1) chk("b81_done_last", done[1], 1'b1);
    end
    chk("b81_strobes", nstb, W + PB);
    chk("b81_done_cnt", ndone, 1);
    pulse_reset();

    // Back-to-back on A: 0x0F then 0xF0 held valid
    @(posedge clk); #2 vld[0] = 1'b1; dat[0] = 8'h0F;
    @(posedge clk); #2 dat[0] = 8'hF0;
    for (int k = 0; k < W + PB; k++) begin
      @(negedge clk);
      chk("b2b_ser0f", ser[0], (k < 4));
      if (k == W + PB - 1) begin
        chk("b2b_done", done[0], 1'b1);
        chk("b2b_rdy", rdy[0], 1'b1);
      end else begin
        chk("b2b_nrdy", rdy[0], 1'b0);
      end
    end
    @(posedge clk); #2 vld[0] = 1'b0;
    @(negedge clk);
    chk("b2b_f0_first", ser[0], 1'b0); chk("b2b_f0_stb", stb[0], 1'b1); chk("b2b_f0_busy", bsy[0], 1'b1);
    for (int k = 1; k < W; k++) begin
      @(negedge clk);
      chk("b2b_serf0", ser[0], (k >= 4));
    end
    wait_idle_a();

    // Replay on B: 0x0F, valid low
    send(1, 8'h0F);
    for (int c = 0; c < 2 * lb; c++) begin
      @(negedge clk);
      if (c == lb - 1 || c == 2 * lb - 1) chk("rep_done", done[1], 1'b1);
      if (c == lb) begin chk("rep_stb", stb[1], 1'b1); chk("rep_busy", bsy[1], 1'b1); end
      if (c == lb + 12) chk("rep_bit4", ser[1], 1'b0);
      if (c == lb + 16) chk("rep_bit3", ser[1], 1'b1);
    end
    pulse_reset();

    // Reset mid-frame on A: 0xFF
    send(0, 8'hFF);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mid_ser", ser[0], 1'b1);
    end
    @(posedge clk); #2 sys_rst = 1'b1;
    @(negedge clk);
    chk("mid_nodone", done[0], 1'b0);
    @(posedge clk); #2 sys_rst = 1'b0;
    @(negedge clk);
    chk("mid_ser0", ser[0], 1'b0); chk("mid_busy", bsy[0], 1'b0); chk("mid_done", done[0], 1'b0);
    send(0, 8'h02);
    @(negedge clk); chk("mid_b0", ser[0], 1'b0); chk("mid_b0_stb", stb[0], 1'b1);
    @(negedge clk); chk("mid_b1", ser[0], 1'b1);
    wait_idle_a();

    // Randomised traffic, scoreboard only
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #2;
      sys_rst = ($urandom_range(0, 199) == 0);
      vld[0]  = ($urandom_range(0, 4) == 0);
      dat[0]  = 8'($urandom);
      vld[1]  = ($urandom_range(0, 9) == 0);
      dat[1]  = 8'($urandom);
    end
    @(posedge clk); #2 sys_rst = 1'b0; vld[0] = 1'b0; vld[1] = 1'b0;
    @(negedge clk); @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
